// File: rtl/ins_exec_pkg.sv
// Shared constants and helpers for the jump/branch execution unit.
package ins_exec_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    typedef enum logic [1:0] {
        NONE,
        PUSH,
        POP,
        POPPUSH
    } ras_action_e;

    // x1 and x5 are the link registers used by call/return hints
    function automatic logic isLinkReg(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

    // Return-address stack hint derived from the link-register usage of a jump
    function automatic ras_action_e rasAction(input logic isJal, input logic isJalr,
                                              input logic [4:0] rd, input logic [4:0] rs1);
        logic rdLink;
        logic rs1Link;
        ras_action_e act;
        rdLink  = isLinkReg(rd);
        rs1Link = isLinkReg(rs1);
        act     = NONE;
        if (isJal) begin
            if (rdLink) act = PUSH;
        end else if (isJalr) begin
            if (rdLink && rs1Link) act = (rd == rs1) ? PUSH : POPPUSH;
            else if (rdLink)       act = PUSH;
            else if (rs1Link)      act = POP;
        end
        return act;
    endfunction

endpackage

// File: rtl/ins_exec_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ins_exec_ras
    import ins_exec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            popPush_i,
    input  logic [XLEN-1:0] pushVal_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]   ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   ptrNext;
    logic [PW-1:0]   ptrPrev;

    assign ptrNext = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign ptrPrev = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - 1'b1;
    assign top_o   = mem_q[ptrPrev];
    assign empty_o = (count_q == '0);

    // Stack pointer, occupancy and entries; pop-then-push replaces the top in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (popPush_i && !empty_o) begin
            mem_q[ptrPrev] <= pushVal_i;
        end else if (push_i || popPush_i) begin
            mem_q[ptr_q] <= pushVal_i;
            ptr_q        <= ptrNext;
            if (count_q != CW'(DEPTH)) count_q <= count_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            ptr_q   <= ptrPrev;
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/ins_exec_rv32i_jb.sv
// JAL/JALR/branch execution unit with registered results, exceptions and RAS check.
module ins_exec_rv32i_jb
    import ins_exec_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IALIGN    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op,
    output logic            op_ready,
    input  logic            flush,
    input  logic [6:0]      ins_dec_op,
    input  logic [2:0]      ins_dec_funct3,
    input  logic [XLEN-1:0] reg_pc_val,
    input  logic [4:0]      reg_rs1,
    input  logic [XLEN-1:0] reg_rs1_val,
    input  logic [XLEN-1:0] reg_rs2_val,
    input  logic [4:0]      reg_rd,
    input  logic [XLEN-1:0] imm_ext_ext,
    input  logic            out_ready,
    output logic            out_valid,
    output logic            reg_pc_w_op,
    output logic [XLEN-1:0] reg_pc_w_val,
    output logic            reg_w_op,
    output logic [4:0]      reg_w_reg_idx,
    output logic [XLEN-1:0] reg_w_reg_val,
    output logic            exc_misalign,
    output logic            exc_illegal,
    output logic [XLEN-1:0] exc_tval,
    output logic            ras_pred_ok
);

    typedef struct packed {
        logic            pcWOp;
        logic [XLEN-1:0] pcWVal;
        logic            wOp;
        logic [4:0]      wIdx;
        logic [XLEN-1:0] wVal;
        logic            misalign;
        logic            illegal;
        logic [XLEN-1:0] tval;
        logic            rasOk;
    } result_t;

    result_t         res_d;
    result_t         res_q;
    logic            outValid_q;
    logic            isJal, isJalr, isBranch;
    logic            brTaken, brIllegal, illegal, useTarget, misalign;
    logic [XLEN-1:0] pcTarget, jalrTarget, target, linkVal;
    ras_action_e     rasAct;
    logic [XLEN-1:0] rasTop;
    logic            rasEmpty;
    logic            accept;
    logic            rasEn;

    assign op_ready = !outValid_q || out_ready;
    assign accept   = op && op_ready && (isJal || isJalr || isBranch);
    assign rasEn    = accept && !flush;

    // Decode, compare, target/alignment check and RAS prediction for the presented instruction
    always_comb begin
        isJal      = (ins_dec_op == OP_JAL);
        isJalr     = (ins_dec_op == OP_JALR);
        isBranch   = (ins_dec_op == OP_BRANCH);
        linkVal    = reg_pc_val + XLEN'(4);
        pcTarget   = reg_pc_val + imm_ext_ext;
        jalrTarget = (reg_rs1_val + imm_ext_ext) & ~XLEN'(1);
        brTaken    = 1'b0;
        brIllegal  = 1'b0;
        case (ins_dec_funct3)
            F3_BEQ:  brTaken = (reg_rs1_val == reg_rs2_val);
            F3_BNE:  brTaken = (reg_rs1_val != reg_rs2_val);
            F3_BLT:  brTaken = ($signed(reg_rs1_val) < $signed(reg_rs2_val));
            F3_BGE:  brTaken = ($signed(reg_rs1_val) >= $signed(reg_rs2_val));
            F3_BLTU: brTaken = (reg_rs1_val < reg_rs2_val);
            F3_BGEU: brTaken = (reg_rs1_val >= reg_rs2_val);
            default: brIllegal = 1'b1;
        endcase
        illegal   = (isJalr && (ins_dec_funct3 != F3_JALR)) || (isBranch && brIllegal);
        useTarget = !illegal && (isJal || isJalr || (isBranch && brTaken));
        target    = isJalr ? jalrTarget : pcTarget;
        misalign  = useTarget && ((IALIGN == 16) ? target[0] : (target[1:0] != 2'b00));
        rasAct    = (illegal || misalign) ? NONE : rasAction(isJal, isJalr, reg_rd, reg_rs1);

        res_d          = '0;
        res_d.pcWOp    = useTarget && !misalign;
        res_d.misalign = misalign;
        res_d.illegal  = illegal;
        res_d.rasOk    = ((rasAct == POP) || (rasAct == POPPUSH)) && !rasEmpty &&
                         (rasTop == jalrTarget);
        if (res_d.pcWOp) res_d.pcWVal = target;
        if ((isJal || isJalr) && !illegal && !misalign && (reg_rd != 5'd0)) begin
            res_d.wOp  = 1'b1;
            res_d.wIdx = reg_rd;
            res_d.wVal = linkVal;
        end
        if (illegal)       res_d.tval = reg_pc_val;
        else if (misalign) res_d.tval = target;
    end

    // Result register: flush wins, then acceptance, then drain when consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            res_q      <= '0;
        end else if (flush) begin
            outValid_q <= 1'b0;
            res_q      <= '0;
        end else if (accept) begin
            outValid_q <= 1'b1;
            res_q      <= res_d;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
            res_q      <= '0;
        end
    end

    generate
        if (RAS_DEPTH > 0) begin : gRas
            ins_exec_ras #(.DEPTH(RAS_DEPTH), .XLEN(XLEN)) uRas (
                .clk       (clk),
                .rst       (rst),
                .push_i    (rasEn && (rasAct == PUSH)),
                .pop_i     (rasEn && (rasAct == POP)),
                .popPush_i (rasEn && (rasAct == POPPUSH)),
                .pushVal_i (linkVal),
                .top_o     (rasTop),
                .empty_o   (rasEmpty)
            );
        end else begin : gNoRas
            assign rasTop   = '0;
            assign rasEmpty = 1'b1;
        end
    endgenerate

    assign out_valid     = outValid_q;
    assign reg_pc_w_op   = res_q.pcWOp;
    assign reg_pc_w_val  = res_q.pcWVal;
    assign reg_w_op      = res_q.wOp;
    assign reg_w_reg_idx = res_q.wIdx;
    assign reg_w_reg_val = res_q.wVal;
    assign exc_misalign  = res_q.misalign;
    assign exc_illegal   = res_q.illegal;
    assign exc_tval      = res_q.tval;
    assign ras_pred_ok   = res_q.rasOk;

endmodule

// File: doc/ins_exec_rv32i_jb.md
Name: ins_exec_rv32i_jb

Overview:
Parametrised jump/branch execution unit covering JAL, JALR and all six conditional branches. It replaces the single-instruction, combinational JAL executor. The block registers its results behind a valid/ready handshake, raises misaligned-target and illegal-funct3 exceptions, and keeps a return-address stack (RAS) that checks JALR return targets. It sits between the decoder/register-read stage and the PC/register-file write-back.

Parameters:
XLEN, 32, datapath width for PC, operands, immediate and results.
IALIGN, 32, instruction alignment in bits: 32 faults when target[1:0]!=0; 16 faults only when target[0]!=0.
RAS_DEPTH, 4, number of return-address stack entries; 0 removes the RAS, and ras_pred_ok is then tied to 0.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
op  in  1  input valid: an instruction is presented
op_ready  out  1  block can accept an instruction this cycle
flush  in  1  discard the held result
ins_dec_op  in  7  major opcode
ins_dec_funct3  in  3  funct3 field
reg_pc_val  in  XLEN  PC of the instruction
reg_rs1  in  5  rs1 index
reg_rs1_val  in  XLEN  rs1 value
reg_rs2_val  in  XLEN  rs2 value
reg_rd  in  5  rd index
imm_ext_ext  in  XLEN  sign-extended byte-offset immediate, bit0 already 0 for J/B types
out_ready  in  1  consumer accepts the result
out_valid  out  1  result registers hold a valid result
reg_pc_w_op  out  1  write PC
reg_pc_w_val  out  XLEN  new PC
reg_w_op  out  1  write rd
reg_w_reg_idx  out  5  rd index
reg_w_reg_val  out  XLEN  link value
exc_misalign  out  1  target is misaligned
exc_illegal  out  1  funct3 illegal for this opcode
exc_tval  out  XLEN  faulting target, or the PC for an illegal funct3
ras_pred_ok  out  1  RAS pop matched the actual JALR target

Behaviour:
- Reset: every output is 0, op_ready is 1, and the RAS is empty (count 0, pointer 0).
- Handshake: op_ready = !out_valid || out_ready. An instruction is accepted when op && op_ready. The result registers load on the next edge, so latency is 1 cycle. They hold steady while out_valid && !out_ready. Back-to-back acceptance runs at 1 instruction per cycle.
- Opcodes other than 1101111, 1100111 and 1100011 are ignored: no acceptance and no state change.
- JAL (1101111): target = pc + imm.
- JALR (1100111, funct3 000): target = (rs1_val + imm) & ~1. Any other funct3 sets exc_illegal.
- BRANCH (1100011) conditions:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011 set exc_illegal.
- Branch target: taken, target = pc + imm; not taken, reg_pc_w_op = 0.
- Jumps: reg_w_op = 1 and reg_w_reg_val = pc + 4, except when rd = 0, which gives reg_w_op = 0. All arithmetic wraps modulo 2^XLEN.
- Misalignment is checked only when the target is used (jump, or taken branch):
  - On fault: exc_misalign = 1, exc_tval = target, reg_pc_w_op = 0, reg_w_op = 0, no RAS update.
  - A not-taken branch with a misaligned target does not fault.
- Exceptions are exclusive: at most one of exc_misalign or exc_illegal is set, and any exception suppresses all writes.
- RAS actions (link register = x1 or x5):
  - JAL with link rd: push pc + 4.
  - JALR, rd not link, rs1 link: pop.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd link, rs1 link, rd != rs1: pop, then push.
  - JALR, rd link, rs1 link, rd == rs1: push.
- ras_pred_ok = 1 only on a JALR that pops a non-empty stack whose top equals the actual target. Otherwise it is 0.
- RAS overflow: a push when full overwrites the oldest entry (circular pointer); count saturates at RAS_DEPTH.
- RAS underflow: a pop when empty gives ras_pred_ok = 0, and count stays 0.
- RAS updates at acceptance time, so updates stay in program order.
- flush:
  - Clears out_valid on the next edge and takes priority over a simultaneous acceptance, which is dropped.
  - The RAS is not rolled back, and the dropped instruction does not update it.
- Reset asserted mid-operation: result and RAS are cleared immediately (asynchronously), with no partial write.

Decomposition:
- Shared package (ins_exec_pkg) holds:
  - Opcode constants: OP_JAL, OP_JALR, OP_BRANCH.
  - funct3 constants: F3_BEQ through F3_BGEU, F3_JALR.
  - Link register indices: REG_RA = 1, REG_T0 = 5.
  - An enumerated RAS action type: NONE, PUSH, POP, POPPUSH.
- Sub-module ins_exec_ras: a parametrised circular stack with push/pop/popthenpush inputs, top and empty outputs, clk and rst.

Test Plan:
- JAL, pc = 0x100, imm = 0x20, rd = 1 -> out_valid one cycle later; pc_w 0x120; rd x1 = 0x104; RAS count 1.
- Follow-up JALR, rs1 = 1, rs1_val = 0x104, imm = 0, rd = 0 -> pc_w 0x104, reg_w_op = 0, ras_pred_ok = 1, RAS empty.
- rs1 = 0xFFFFFFFF, rs2 = 1:
  - BLT -> taken, pc_w = pc + imm.
  - BLTU -> reg_pc_w_op = 0.
  - funct3 = 010 -> exc_illegal = 1, no writes.
- IALIGN = 32:
  - JAL, pc = 0x100, imm = 0x2 -> exc_misalign = 1, exc_tval = 0x102, no writes.
  - Same instruction with IALIGN = 16 -> pc_w 0x102.
- Backpressure: accept with out_ready = 0 -> op_ready = 0 and outputs held unchanged for 3 cycles; out_ready = 1 -> next instruction accepted that edge.
- RAS_DEPTH = 4:
  - 5 link JALs pushing A..E, then 5 returns -> ras_pred_ok 1 for E, D, C, B; 0 for the fifth.
  - Assert rst mid-sequence -> all outputs 0 immediately.
